// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings, NOP word,
// default boot address and the IF/ID slot layout.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IF_ST_IDLE = 2'd0,
        IF_ST_REQ  = 2'd1,
        IF_ST_HOLD = 2'd2,
        IF_ST_DROP = 2'd3
    } if_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic        err;
        logic        valid;
    } fetch_slot_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs single-outstanding reads on the
// instruction bus and drives the IF/ID register seen by the decoder.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        exc_taken,
    input  logic [31:0] exc_vector,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] inst_code,
    output logic [31:0] pc_addr,
    output logic        inst_valid,
    output logic        fetch_err
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    fetch_slot_t ifid_q, ifid_d;
    fetch_slot_t hold_q, hold_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_tgt_q, br_tgt_d;
    logic        err_sent_q, err_sent_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;

    logic free;
    logic acked;
    logic br_now;

    assign free   = !ifid_q.valid || !stall;
    assign acked  = req_q && ibus_ack;
    assign br_now = branch_taken && !stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_d     = ifid_q;
        hold_d     = hold_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;
        err_sent_d = err_sent_q;
        req_d      = 1'b0;
        addr_d     = addr_q;

        if (free) begin
            ifid_d.valid = 1'b0;
            ifid_d.code  = INST_NOP;
            ifid_d.err   = 1'b0;
        end

        unique case (state_q)
            IF_ST_IDLE: state_d = IF_ST_REQ;

            IF_ST_REQ: begin
                if (acked) begin
                    if (free) begin
                        ifid_d.code  = ibus_rdata;
                        ifid_d.pc    = pc_q;
                        ifid_d.err   = 1'b0;
                        ifid_d.valid = 1'b1;
                    end else begin
                        hold_d.code  = ibus_rdata;
                        hold_d.pc    = pc_q;
                        hold_d.err   = 1'b0;
                        hold_d.valid = 1'b1;
                        state_d      = IF_ST_HOLD;
                    end
                    pc_d      = br_pend_q ? br_tgt_q : pc_q + 32'd4;
                    br_pend_d = 1'b0;
                    // The response arriving now is the delay slot, so redirect straight away.
                    if (br_now) begin
                        pc_d = branch_addr;
                    end
                end else begin
                    if (is_misaligned(pc_q) && !err_sent_q && free) begin
                        ifid_d.code  = INST_NOP;
                        ifid_d.pc    = pc_q;
                        ifid_d.err   = 1'b1;
                        ifid_d.valid = 1'b1;
                        err_sent_d   = 1'b1;
                    end
                    if (br_now) begin
                        br_pend_d = 1'b1;
                        br_tgt_d  = branch_addr;
                    end
                end
            end

            IF_ST_HOLD: begin
                if (free) begin
                    ifid_d  = hold_q;
                    hold_d  = '0;
                    state_d = IF_ST_REQ;
                    // Delay slot is already parked; nothing past it has been requested.
                    if (br_now) begin
                        pc_d = branch_addr;
                    end
                end
            end

            IF_ST_DROP: begin
                if (ibus_ack) begin
                    state_d = IF_ST_REQ;
                end
            end

            default: state_d = IF_ST_IDLE;
        endcase

        if (exc_taken) begin
            ifid_d.valid = 1'b0;
            ifid_d.code  = INST_NOP;
            ifid_d.err   = 1'b0;
            hold_d       = '0;
            br_pend_d    = 1'b0;
            err_sent_d   = 1'b0;
            pc_d         = exc_vector;
            state_d      = (req_q && !ibus_ack) ? IF_ST_DROP : IF_ST_REQ;
        end

        // A dropped read must keep its address on the bus until the slave answers.
        if (state_d == IF_ST_DROP) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else if (state_d == IF_ST_REQ && !is_misaligned(pc_d)) begin
            req_d  = 1'b1;
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_ST_IDLE;
            pc_q       <= RESET_PC;
            ifid_q     <= '0;
            hold_q     <= '0;
            br_pend_q  <= 1'b0;
            br_tgt_q   <= '0;
            err_sent_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            hold_q     <= hold_d;
            br_pend_q  <= br_pend_d;
            br_tgt_q   <= br_tgt_d;
            err_sent_q <= err_sent_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    assign ibus_req   = req_q;
    assign ibus_addr  = addr_q;
    assign inst_code  = ifid_q.code;
    assign pc_addr    = ifid_q.pc;
    assign inst_valid = ifid_q.valid;
    assign fetch_err  = ifid_q.err;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a latency-programmable bus slave returns ~addr as
// the instruction word and a scoreboard checks every instruction the decoder consumes.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        exc_taken = 1'b0;
    logic [31:0] exc_vector = '0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] inst_code;
    logic [31:0] pc_addr;
    logic        inst_valid;
    logic        fetch_err;

    if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .exc_taken(exc_taken), .exc_vector(exc_vector),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .inst_code(inst_code), .pc_addr(pc_addr),
        .inst_valid(inst_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] code;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ack_log[$];
    int          bus_lat = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] b32(input logic b);
        return {31'b0, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic log_has(input logic [31:0] a);
        foreach (ack_log[i]) if (ack_log[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic [31:0] a);
        exp_q.push_back('{a, ~a, 1'b0});
    endtask

    task automatic push_range(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 32'(4 * i));
    endtask

    // Bus slave: answers each request bus_lat cycles after it is first seen.
    initial begin : bus_slave
        int cnt;
        cnt = 0;
        ibus_ack = 1'b0;
        ibus_rdata = '0;
        forever begin
            @(negedge clk);
            ibus_ack = 1'b0;
            if (!rst && ibus_req === 1'b1) begin
                if (cnt >= bus_lat) begin
                    ibus_ack = 1'b1;
                    ibus_rdata = ~ibus_addr;
                    ack_log.push_back(ibus_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Consumer side: an instruction is taken by ID at the edge after it is valid with !stall.
    initial begin : consumer
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid === 1'b1 && stall === 1'b0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ifid_pc", pc_addr, e.pc);
                check("ifid_code", inst_code, e.code);
                check("ifid_err", b32(fetch_err), b32(e.err));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int lat);
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        exc_taken = 1'b0;
        branch_addr = '0;
        exc_vector = '0;
        bus_lat = lat;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        ack_log.delete();
        check("rst_req", b32(ibus_req), 32'd0);
        check("rst_addr", ibus_addr, 32'd0);
        check("rst_code", inst_code, 32'd0);
        check("rst_pc", pc_addr, 32'd0);
        check("rst_valid", b32(inst_valid), 32'd0);
        check("rst_err", b32(fetch_err), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_pc_pos(input logic [31:0] a);
        for (int i = 0; i < 200; i++) begin
            if (inst_valid === 1'b1 && pc_addr === a) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pc_neg(input logic [31:0] a);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inst_valid === 1'b1 && pc_addr === a) break;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stimulus
        // 1: back-to-back fetch from the boot address
        do_reset(0);
        push_range(32'hBFC0_0000, 8);
        @(posedge clk); #1;
        check("t1_req", b32(ibus_req), 32'd1);
        check("t1_addr0", ibus_addr, 32'hBFC0_0000);
        check("t1_not_yet_valid", b32(inst_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_first_valid", b32(inst_valid), 32'd1);
        check("t1_first_pc", pc_addr, 32'hBFC0_0000);
        drain("t1_drain");
        check("t1_log0", ack_log[0], 32'hBFC0_0000);
        check("t1_log1", ack_log[1], 32'hBFC0_0004);
        check("t1_log2", ack_log[2], 32'hBFC0_0008);

        // 2: stall for three cycles while a response arrives
        do_reset(0);
        push_range(32'hBFC0_0000, 6);
        wait_pc_pos(32'hBFC0_0004);
        check("t2_at_04", pc_addr, 32'hBFC0_0004);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t2_req_parked", b32(ibus_req), 32'd0);
            check("t2_pc_held", pc_addr, 32'hBFC0_0004);
            check("t2_code_held", inst_code, ~32'hBFC0_0004);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        check("t2_release_pc", pc_addr, 32'hBFC0_0008);
        check("t2_release_valid", b32(inst_valid), 32'd1);
        @(posedge clk); #1;
        check("t2_next_pc", pc_addr, 32'hBFC0_000C);
        drain("t2_drain");

        // 3: branch with delay slot still in flight on a slow bus
        do_reset(2);
        push_range(32'hBFC0_0000, 6);
        push(32'h8000_0100);
        push(32'h8000_0104);
        wait_pc_neg(32'hBFC0_0010);
        check("t3_at_branch", pc_addr, 32'hBFC0_0010);
        branch_taken = 1'b1;
        branch_addr = 32'h8000_0100;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        drain("t3_drain");
        check("t3_no_fetch_18", b32(log_has(32'hBFC0_0018)), 32'd0);

        // 4: branch with delay slot parked in the hold buffer
        do_reset(0);
        push_range(32'hBFC0_0000, 6);
        push(32'h8000_0100);
        push(32'h8000_0104);
        wait_pc_pos(32'hBFC0_0010);
        check("t4_at_branch", pc_addr, 32'hBFC0_0010);
        stall = 1'b1;
        @(posedge clk); #1;
        check("t4_hold_req", b32(ibus_req), 32'd0);
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_addr = 32'h8000_0100;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        check("t4_redirect_req", b32(ibus_req), 32'd1);
        check("t4_redirect_addr", ibus_addr, 32'h8000_0100);
        check("t4_delay_slot", pc_addr, 32'hBFC0_0014);
        drain("t4_drain");
        check("t4_no_fetch_18", b32(log_has(32'hBFC0_0018)), 32'd0);

        // 5a: exception while a read is outstanding, under stall
        do_reset(3);
        stall = 1'b1;
        wait_pc_pos(32'hBFC0_0000);
        check("t5_at_00", pc_addr, 32'hBFC0_0000);
        exc_taken = 1'b1;
        exc_vector = 32'h8000_0180;
        @(posedge clk); #1;
        exc_taken = 1'b0;
        stall = 1'b0;
        check("t5_flush_valid", b32(inst_valid), 32'd0);
        check("t5_flush_code", inst_code, 32'd0);
        check("t5_drop_req", b32(ibus_req), 32'd1);
        check("t5_drop_addr", ibus_addr, 32'hBFC0_0004);
        push(32'h8000_0180);
        push(32'h8000_0184);
        for (int i = 0; i < 50; i++) begin
            if (ibus_req === 1'b1 && ibus_addr !== 32'hBFC0_0004) break;
            @(posedge clk); #1;
        end
        check("t5_vector_addr", ibus_addr, 32'h8000_0180);
        drain("t5_drain");

        // 5b: exception and branch in the same cycle
        do_reset(0);
        push_range(32'hBFC0_0000, 3);
        wait_pc_neg(32'hBFC0_0008);
        check("t5b_at_08", pc_addr, 32'hBFC0_0008);
        exc_taken = 1'b1;
        exc_vector = 32'h8000_0180;
        branch_taken = 1'b1;
        branch_addr = 32'h8000_0100;
        @(posedge clk); #1;
        exc_taken = 1'b0;
        branch_taken = 1'b0;
        push(32'h8000_0180);
        push(32'h8000_0184);
        check("t5b_valid", b32(inst_valid), 32'd0);
        check("t5b_addr", ibus_addr, 32'h8000_0180);
        drain("t5b_drain");
        check("t5b_no_branch", b32(log_has(32'h8000_0100)), 32'd0);

        // 6: branch to a misaligned target raises fetch_err without a bus read
        do_reset(1);
        push_range(32'hBFC0_0000, 3);
        exp_q.push_back('{32'h8000_0102, 32'h0, 1'b1});
        wait_pc_neg(32'hBFC0_0004);
        check("t6_at_branch", pc_addr, 32'hBFC0_0004);
        branch_taken = 1'b1;
        branch_addr = 32'h8000_0102;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        drain("t6_drain");
        repeat (4) @(posedge clk);
        #1;
        check("t6_idle_req", b32(ibus_req), 32'd0);
        check("t6_no_fetch", b32(log_has(32'h8000_0102)), 32'd0);
        exc_taken = 1'b1;
        exc_vector = 32'h8000_0180;
        @(posedge clk); #1;
        exc_taken = 1'b0;
        check("t6_recover_req", b32(ibus_req), 32'd1);
        check("t6_recover_addr", ibus_addr, 32'h8000_0180);
        check("t6_err_cleared", b32(fetch_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
